wc_tile_ctrl: RTL

Sequencer in front of the Winograd core `wc`, which takes an 80-bit tile of eight signed 10-bit samples and returns a 40-bit block of four signed 10-bit results a fixed number of cycles later.
- Accepts a serial sample stream with valid/ready and framing.
- Assembles overlapping 8-sample tiles, drives `wc` D from a held register, and counts the core latency.
- Captures Z and presents each result block on a valid/ready output port.
- Sits between the line-buffer/stream source and the downstream accumulator.

---
 rtl/wc_tile_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/wc_tile_ctrl.sv
// -----------------------------------------------------------------------------
// wc_tile_ctrl
//
// Sequencer in front of the Winograd core `wc`. It collects a serial stream
// of signed samples into overlapping 8-sample tiles, launches each tile on
// wc_D (held until the next launch), waits the fixed core latency, captures
// wc_Z and presents it downstream on a valid/ready port.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (0 = reset)
//   s_valid   input sample valid
//   s_ready   controller can accept a sample
//   s_data    signed sample
//   s_last    last sample of frame (qualified by s_valid & s_ready)
//   wc_D      tile to core; sample 0 in the top slice, sample 7 in the bottom
//   wc_Z      core result; result 0 in the top slice
//   m_valid   result block valid
//   m_ready   downstream accepts block
//   m_data    captured wc_Z
//   m_last    block is the final tile of a frame
//   busy      tile in flight or result pending
//
// Optional build macro WC_TILE_CTRL_PERF_EN adds:
//   tile_cnt  saturating count of tile launches
//   stall_cnt saturating count of cycles with m_valid & !m_ready
// -----------------------------------------------------------------------------
module wc_tile_ctrl #(
  parameter int LAT     = 6,
  parameter int OVERLAP = 4,
  parameter int DATA_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic [8*DATA_W-1:0]      wc_D,
  input  logic [4*DATA_W-1:0]      wc_Z,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [4*DATA_W-1:0]      m_data,
  output logic                     m_last,
  output logic                     busy
`ifdef WC_TILE_CTRL_PERF_EN
  ,
  output logic [15:0]              tile_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int TILE_W = 8 * DATA_W;
  localparam int RES_W  = 4 * DATA_W;
  localparam int LAT_W  = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  tbuf_q [8];
  logic signed [DATA_W-1:0]  tbuf_d [8];
  logic [3:0]                fill_q, fill_d;
  logic                      tile_rdy_q, tile_rdy_d;
  logic                      tile_last_q, tile_last_d;
  logic                      last_q, last_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [TILE_W-1:0]         wc_d_q, wc_d_d;
  logic                      m_valid_q, m_valid_d;
  logic [RES_W-1:0]          m_data_q, m_data_d;
  logic                      m_last_q, m_last_d;
  logic                      live_q;

  logic accept;
  logic mv_post;
  logic issue;

  // live_q keeps s_ready low while reset is held and lifts it on the
  // first clock after release.
  assign s_ready = live_q && (fill_q < 4'd8) && !tile_rdy_q;
  assign accept  = s_valid && s_ready;
  // Issue decisions look at m_valid as it will be after this cycle's
  // downstream handshake, so a drain and a new launch can share a cycle.
  assign mv_post = m_valid_q && !m_ready;
  assign issue   = (state_q == ST_IDLE) && tile_rdy_q && !mv_post;

  always_comb begin
    state_d     = state_q;
    tbuf_d      = tbuf_q;
    fill_d      = fill_q;
    tile_rdy_d  = tile_rdy_q;
    tile_last_d = tile_last_q;
    last_d      = last_q;
    lat_d       = lat_q;
    wc_d_d      = wc_d_q;
    m_valid_d   = mv_post;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;

    if (accept) begin
      for (int i = 0; i < 8; i++) begin
        if (fill_q == 4'(i)) begin
          tbuf_d[i] = s_data;
        end else if (s_last && (fill_q < 4'(i))) begin
          // short frame tail: slots past the last sample read as zero
          tbuf_d[i] = '0;
        end
      end
      fill_d = fill_q + 4'd1;
      if (s_last || (fill_q == 4'd7)) begin
        tile_rdy_d  = 1'b1;
        tile_last_d = s_last;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          for (int i = 0; i < 8; i++) begin
            wc_d_d[TILE_W-1-DATA_W*i -: DATA_W] = tbuf_q[i];
          end
          last_d      = tile_last_q;
          lat_d       = '0;
          state_d     = ST_WAIT;
          tile_rdy_d  = 1'b0;
          tile_last_d = 1'b0;
          if (tile_last_q) begin
            // frame boundary: next frame starts with no retained samples
            for (int i = 0; i < 8; i++) begin
              tbuf_d[i] = '0;
            end
            fill_d = 4'd0;
          end else begin
            // slide the tail of this tile to the head of the next one
            for (int i = 0; i < OVERLAP; i++) begin
              tbuf_d[i] = tbuf_q[8-OVERLAP+i];
            end
            fill_d = 4'(OVERLAP);
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(LAT - 1)) begin
          m_data_d  = wc_Z;
          m_last_d  = last_q;
          m_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 8; i++) begin
        tbuf_q[i] <= '0;
      end
      fill_q      <= '0;
      tile_rdy_q  <= 1'b0;
      tile_last_q <= 1'b0;
      last_q      <= 1'b0;
      lat_q       <= '0;
      wc_d_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbuf_q      <= tbuf_d;
      fill_q      <= fill_d;
      tile_rdy_q  <= tile_rdy_d;
      tile_last_q <= tile_last_d;
      last_q      <= last_d;
      lat_q       <= lat_d;
      wc_d_q      <= wc_d_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      live_q      <= 1'b1;
    end
  end

  assign wc_D    = wc_d_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q == ST_WAIT) || m_valid_q;

`ifdef WC_TILE_CTRL_PERF_EN
  logic [15:0] tile_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue && (tile_cnt_q != 16'hFFFF)) begin
        tile_cnt_q <= tile_cnt_q + 16'd1;
      end
      if (m_valid_q && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign tile_cnt  = tile_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
